// File: rtl/uart_tx.sv
// UART transmitter: an AXI-Stream slave feeds a one-entry holding register,
// and a start/data/parity/stop serialiser drives a registered, idle-high line.
module uart_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  tx_wire,
    output logic                  tx_busy
);
    localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W     = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int BIT_MAX    = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
    localparam int BIT_W      = $clog2(BIT_MAX + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_PERIOD - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (BIT_PERIOD < 2) begin : g_bad_period
        $error("uart_tx: BIT_PERIOD = CLK_FREQ / BAUD_RATE must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q;
    logic [BAUD_W-1:0]     baud_q;
    logic [BIT_W-1:0]      bit_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  parity_q;
    logic [DATA_WIDTH-1:0] hold_data_q;
    logic                  hold_valid_q;
    logic                  tx_q;

    logic baud_end_d;
    logic accept_d;
    logic parity_d;

    always_comb begin
        baud_end_d = (baud_q == BAUD_LAST);
        accept_d   = s_axis_tvalid & ~hold_valid_q;
        parity_d   = (PARITY == 1) ? ~(^hold_data_q) : (^hold_data_q);
    end

    assign s_axis_tready = ~hold_valid_q;
    assign tx_wire       = tx_q;
    assign tx_busy       = (state_q != S_IDLE) | hold_valid_q;

    // Loading and accepting never coincide: a load needs hold_valid_q=1,
    // an accept needs it to be 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            tx_q         <= 1'b1;
        end else begin
            if (accept_d) begin
                hold_data_q  <= s_axis_tdata;
                hold_valid_q <= 1'b1;
            end

            if (state_q != S_IDLE) begin
                baud_q <= baud_end_d ? '0 : baud_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (hold_valid_q) begin
                        shift_q      <= hold_data_q;
                        parity_q     <= parity_d;
                        hold_valid_q <= 1'b0;
                        baud_q       <= '0;
                        bit_q        <= '0;
                        tx_q         <= 1'b0;
                        state_q      <= S_START;
                    end
                end
                S_START: begin
                    if (baud_end_d) begin
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
                        bit_q   <= '0;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_end_d) begin
                        if (bit_q == DATA_LAST) begin
                            bit_q <= '0;
                            if (PARITY != 0) begin
                                tx_q    <= parity_q;
                                state_q <= S_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_end_d) begin
                        tx_q    <= 1'b1;
                        bit_q   <= '0;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (baud_end_d) begin
                        if (bit_q == STOP_LAST) begin
                            bit_q <= '0;
                            // A pending word starts on this same edge: no idle gap.
                            if (hold_valid_q) begin
                                shift_q      <= hold_data_q;
                                parity_q     <= parity_d;
                                hold_valid_q <= 1'b0;
                                tx_q         <= 1'b0;
                                state_q      <= S_START;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four lanes with different parity/stop settings, a line
// monitor per lane that rebuilds frames and checks them against a queue.
module tb_uart_tx;
    localparam int NL = 4;
    localparam int W  = 16;
    localparam int PAR  [NL] = '{0, 2, 1, 0};
    localparam int STP  [NL] = '{1, 1, 1, 2};
    localparam int FLEN [NL] = '{10, 11, 11, 11};

    logic          clk;
    logic          rst_n;
    logic [7:0]    tdata [NL];
    logic [NL-1:0] tvalid;
    logic [NL-1:0] tready;
    logic [NL-1:0] tx_wire;
    logic [NL-1:0] busy;

    int vectors = 0;
    int errors  = 0;
    logic [W-1:0] exp_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // frame: bit0 = start, then data LSB first, parity (if any), stop bits
    task automatic send(input int idx, input logic [7:0] d, input logic [11:0] f);
        int n;
        @(negedge clk);
        tdata[idx]  = d;
        tvalid[idx] = 1'b1;
        n = 0;
        while (tready[idx] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            vectors++;
            errors++;
            $display("FAIL send_timeout lane %0d: tready stayed %b, required 1", idx, tready[idx]);
        end
        exp_q.push_back({idx[3:0], f});
        @(posedge clk);
        #1;
        tvalid[idx] = 1'b0;
    endtask

    for (genvar g = 0; g < NL; g++) begin : g_lane
        uart_tx #(
            .CLK_FREQ   (1_000_000),
            .BAUD_RATE  (100_000),
            .DATA_WIDTH (8),
            .PARITY     (PAR[g]),
            .STOP_BITS  (STP[g])
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .s_axis_tdata  (tdata[g]),
            .s_axis_tvalid (tvalid[g]),
            .s_axis_tready (tready[g]),
            .tx_wire       (tx_wire[g]),
            .tx_busy       (busy[g])
        );

        // monitor: every bit must hold one value for all 10 clocks
        initial begin : mon
            logic [11:0]  fr;
            logic         first;
            logic         stable;
            logic         aborted;
            logic [W-1:0] exp_v;
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1 && tx_wire[g] === 1'b0) begin
                    fr      = '0;
                    aborted = 1'b0;
                    for (int b = 0; b < FLEN[g]; b++) begin
                        stable = 1'b1;
                        first  = 1'b0;
                        for (int c = 0; c < 10; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (rst_n !== 1'b1) aborted = 1'b1;
                            if (c == 0) first = tx_wire[g];
                            else if (tx_wire[g] !== first) stable = 1'b0;
                        end
                        fr[b] = stable ? first : 1'bx;
                    end
                    if (!aborted) begin
                        if (exp_q.size() == 0) begin
                            vectors++;
                            errors++;
                            $display("FAIL unexpected_frame lane %0d: got %h, required none", g, fr);
                        end else begin
                            exp_v = exp_q.pop_front();
                            check($sformatf("frame_lane%0d", g), {4'(g), fr}, exp_v);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        tvalid = '0;
        for (int i = 0; i < NL; i++) tdata[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // idle after reset
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("reset_idle", {4'h0, tx_wire, tready, busy}, 16'h0FF0);
        end

        // lane 0, no parity: 0xA5
        send(0, 8'hA5, 12'h34A);
        check("a5_k_wire",  {15'h0, tx_wire[0]}, 16'h1);
        check("a5_k_busy",  {15'h0, busy[0]}, 16'h1);
        check("a5_k_ready", {15'h0, tready[0]}, 16'h0);
        @(posedge clk); #1;
        check("a5_start_latency", {14'h0, tx_wire[0], tready[0]}, 16'h1);
        repeat (99) @(posedge clk);
        #1;
        check("a5_k100", {14'h0, tx_wire[0], busy[0]}, 16'h3);
        @(posedge clk); #1;
        check("a5_k101", {13'h0, tx_wire[0], busy[0], tready[0]}, 16'h5);

        // lane 1 even parity, lane 2 odd parity: 110-cycle frames
        send(1, 8'hA5, 12'h54A);
        repeat (110) @(posedge clk);
        #1;
        check("even_k110_busy", {15'h0, busy[1]}, 16'h1);
        @(posedge clk); #1;
        check("even_k111_busy", {15'h0, busy[1]}, 16'h0);

        send(2, 8'hA5, 12'h74A);
        repeat (110) @(posedge clk);
        #1;
        check("odd_k110_busy", {15'h0, busy[2]}, 16'h1);
        @(posedge clk); #1;
        check("odd_k111_busy", {15'h0, busy[2]}, 16'h0);

        // lane 3, two stop bits: 0x00
        send(3, 8'h00, 12'h600);
        repeat (90) @(posedge clk);
        #1;
        check("s2_k90_wire", {15'h0, tx_wire[3]}, 16'h0);
        @(posedge clk); #1;
        check("s2_k91_wire", {15'h0, tx_wire[3]}, 16'h1);
        repeat (19) @(posedge clk);
        #1;
        check("s2_k110", {14'h0, tx_wire[3], busy[3]}, 16'h3);
        @(posedge clk); #1;
        check("s2_k111", {14'h0, tx_wire[3], busy[3]}, 16'h2);

        // back-to-back on lane 0 with tvalid held high
        @(negedge clk);
        tdata[0]  = 8'h3C;
        tvalid[0] = 1'b1;
        exp_q.push_back({4'd0, 12'h278});
        @(posedge clk); #1;
        check("b2b_k_ready", {15'h0, tready[0]}, 16'h0);
        tdata[0] = 8'hC3;
        exp_q.push_back({4'd0, 12'h386});
        @(posedge clk); #1;
        check("b2b_k1", {14'h0, tx_wire[0], tready[0]}, 16'h1);
        @(posedge clk); #1;
        check("b2b_k2_ready", {15'h0, tready[0]}, 16'h0);
        tdata[0] = 8'h5A;
        exp_q.push_back({4'd0, 12'h2B4});
        repeat (98) @(posedge clk);
        #1;
        check("b2b_k100", {14'h0, tx_wire[0], tready[0]}, 16'h2);
        @(posedge clk); #1;
        check("b2b_k101_no_gap", {14'h0, tx_wire[0], tready[0]}, 16'h1);
        @(posedge clk); #1;
        check("b2b_k102_ready", {15'h0, tready[0]}, 16'h0);
        tvalid[0] = 1'b0;
        repeat (210) @(posedge clk);
        #1;
        check("b2b_done_busy", {15'h0, busy[0]}, 16'h0);

        // reset during data bit 3 of 0xFF with 0x81 pending
        @(negedge clk);
        tdata[0]  = 8'hFF;
        tvalid[0] = 1'b1;
        @(posedge clk); #1;
        tdata[0] = 8'h81;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tvalid[0] = 1'b0;
        check("rst_pending_ready", {15'h0, tready[0]}, 16'h0);
        repeat (42) @(posedge clk);
        #3;
        check("rst_pre_busy", {15'h0, busy[0]}, 16'h1);
        rst_n = 1'b0;
        #1;
        check("rst_async", {13'h0, tx_wire[0], tready[0], busy[0]}, 16'h6);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check("rst_after_idle", {13'h0, tx_wire[0], tready[0], busy[0]}, 16'h6);
        end

        repeat (20) @(negedge clk);
        check("queue_drained", W'(exp_q.size()), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
